// File: rtl/scan_line_sequencer_if.sv
// ---------------------------------------------------------------------------
// scan_line_sequencer_if
//
// Bundles the control/status signals between the host register block, the
// CCD timing engine and the scan-line sequencer.
//
// Signals:
//   start          host -> seq   single-cycle pass start request
//   abort          host -> seq   single-cycle pass abort request
//   cal_lines[8]   host -> seq   calibration line count (sampled at start)
//   num_lines[W]   host -> seq   image line count (sampled at start)
//   pix_out_valid  engine -> seq line-valid flag, asynchronous to clk_80M
//   ccd_en         seq -> engine enable
//   ccd_cal_mode   seq -> engine calibration mode select
//   busy, cal_active, line_done, line_idx[W], done, aborted, err
//                  seq -> host   status
//
// Modports: master = host/engine side, slave = sequencer.
// ---------------------------------------------------------------------------
interface scan_line_sequencer_if #(
    parameter int LINE_W = 16
);
    logic              start;
    logic              abort;
    logic [7:0]        cal_lines;
    logic [LINE_W-1:0] num_lines;
    logic              pix_out_valid;
    logic              ccd_en;
    logic              ccd_cal_mode;
    logic              busy;
    logic              cal_active;
    logic              line_done;
    logic [LINE_W-1:0] line_idx;
    logic              done;
    logic              aborted;
    logic              err;

    modport master (
        output start, abort, cal_lines, num_lines, pix_out_valid,
        input  ccd_en, ccd_cal_mode, busy, cal_active, line_done,
               line_idx, done, aborted, err
    );

    modport slave (
        input  start, abort, cal_lines, num_lines, pix_out_valid,
        output ccd_en, ccd_cal_mode, busy, cal_active, line_done,
               line_idx, done, aborted, err
    );
endinterface

// File: rtl/scan_line_sequencer.sv
// ---------------------------------------------------------------------------
// scan_line_sequencer
//
// Runs one film-scan pass on the CCD timing engine: cal_lines calibration
// lines (cal_mode=1), a disabled settle gap, then num_lines image lines
// (cal_mode=0). Line ends are the falling edges of the engine's
// pix_out_valid flag after synchronisation into clk_80M. A line that takes
// too long parks the sequencer in ERR with a sticky err flag.
//
// Ports:
//   clk_80M  in   system clock
//   rst_n    in   synchronous active-low reset
//   bus      slave modport of scan_line_sequencer_if (host + engine signals)
//
// All outputs are registered; they are derived from the next state so they
// line up with the state register without a decode stage behind it.
// ---------------------------------------------------------------------------
module scan_line_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 64,
    parameter int LINE_TIMEOUT  = 200000,
    parameter int LINE_W        = 16
) (
    input  logic                  clk_80M,
    input  logic                  rst_n,
    scan_line_sequencer_if.slave  bus
);

    localparam int CNT_W = (LINE_W > 8) ? LINE_W : 8;
    localparam int TMR_W = (LINE_TIMEOUT > 1) ? $clog2(LINE_TIMEOUT) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAL,
        ST_SETTLE,
        ST_SCAN,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   line_cnt_q, line_cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [7:0]         cal_total_q, cal_total_d;
    logic [LINE_W-1:0]  num_total_q, num_total_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pix_prev_q;
    logic                   line_fall;

    logic ccd_en_q, ccd_en_d;
    logic cal_mode_q, cal_mode_d;
    logic busy_q, busy_d;
    logic cal_active_q, cal_active_d;
    logic line_done_q, line_done_d;
    logic done_q, done_d;
    logic aborted_q, aborted_d;
    logic err_q, err_d;

    logic [CNT_W-1:0] phase_total;
    logic             is_last;
    logic             line_end_taken;
    logic             abort_taken;

    // ---------------------------------------------------------------------
    // pix_out_valid synchroniser chain; stage 0 samples the async input.
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = bus.pix_out_valid;
            end else begin : g_chain
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    // A line end is the synchronised flag going 1 -> 0.
    assign line_fall = pix_prev_q & ~sync_q[SYNC_STAGES-1];

    // Line target for whichever counting phase is active.
    assign phase_total = (state_q == ST_CAL) ? CNT_W'(cal_total_q)
                                             : CNT_W'(num_total_q);
    assign is_last     = (line_cnt_q == (phase_total - CNT_W'(1)));

    // ---------------------------------------------------------------------
    // Next-state and output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        line_cnt_d     = line_cnt_q;
        tmr_d          = '0;
        settle_d       = '0;
        cal_total_d    = cal_total_q;
        num_total_d    = num_total_q;
        line_end_taken = 1'b0;
        abort_taken    = 1'b0;

        case (state_q)
            ST_IDLE, ST_ERR: begin
                // ERR behaves like IDLE for a new start; leaving ERR is
                // what clears err.
                if (bus.start) begin
                    cal_total_d = bus.cal_lines;
                    num_total_d = bus.num_lines;
                    line_cnt_d  = '0;
                    if (bus.cal_lines != 8'd0) begin
                        state_d = ST_CAL;
                    end else if (bus.num_lines != '0) begin
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_CAL, ST_SCAN: begin
                // abort beats timeout beats line end, so a line end that
                // lands on an abort or timeout is simply dropped.
                if (bus.abort) begin
                    abort_taken = 1'b1;
                    line_cnt_d  = '0;
                    state_d     = ST_IDLE;
                end else if (tmr_q == TMR_W'(LINE_TIMEOUT - 1)) begin
                    line_cnt_d = '0;
                    state_d    = ST_ERR;
                end else if (line_fall) begin
                    line_end_taken = 1'b1;
                    if (is_last) begin
                        line_cnt_d = '0;
                        if (state_q == ST_CAL && num_total_q != '0) begin
                            state_d = ST_SETTLE;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        line_cnt_d = line_cnt_q + CNT_W'(1);
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            ST_SETTLE: begin
                if (bus.abort) begin
                    abort_taken = 1'b1;
                    state_d     = ST_IDLE;
                end else if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_SCAN;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered outputs follow the state being entered.
        ccd_en_d     = (state_d == ST_CAL) || (state_d == ST_SCAN);
        // cal_mode stays up for the first disabled settle cycle so the
        // engine never sees mode change while still enabled.
        cal_mode_d   = (state_d == ST_CAL) ||
                       ((state_d == ST_SETTLE) && (settle_d == '0));
        cal_active_d = (state_d == ST_CAL);
        busy_d       = (state_d == ST_CAL) || (state_d == ST_SETTLE) ||
                       (state_d == ST_SCAN);
        done_d       = (state_d == ST_DONE);
        err_d        = (state_d == ST_ERR);
        line_done_d  = line_end_taken;
        aborted_d    = abort_taken;
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_80M) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            line_cnt_q   <= '0;
            tmr_q        <= '0;
            settle_q     <= '0;
            cal_total_q  <= '0;
            num_total_q  <= '0;
            sync_q       <= '0;
            pix_prev_q   <= 1'b0;
            ccd_en_q     <= 1'b0;
            cal_mode_q   <= 1'b0;
            busy_q       <= 1'b0;
            cal_active_q <= 1'b0;
            line_done_q  <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_cnt_q   <= line_cnt_d;
            tmr_q        <= tmr_d;
            settle_q     <= settle_d;
            cal_total_q  <= cal_total_d;
            num_total_q  <= num_total_d;
            sync_q       <= sync_d;
            pix_prev_q   <= sync_q[SYNC_STAGES-1];
            ccd_en_q     <= ccd_en_d;
            cal_mode_q   <= cal_mode_d;
            busy_q       <= busy_d;
            cal_active_q <= cal_active_d;
            line_done_q  <= line_done_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            err_q        <= err_d;
        end
    end

    assign bus.ccd_en       = ccd_en_q;
    assign bus.ccd_cal_mode = cal_mode_q;
    assign bus.busy         = busy_q;
    assign bus.cal_active   = cal_active_q;
    assign bus.line_done    = line_done_q;
    assign bus.line_idx     = line_cnt_q[LINE_W-1:0];
    assign bus.done         = done_q;
    assign bus.aborted      = aborted_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_scan_line_sequencer.sv
// ---------------------------------------------------------------------------
// tb_scan_line_sequencer
//
// Stimulus tasks plan each pass and push the events the pass must produce
// (enable rise, line end, done, abort, error) with their cycle stamps into a
// queue. A negedge monitor turns every DUT output event into a record, pops
// the queue and compares.
// ---------------------------------------------------------------------------
module tb_scan_line_sequencer;

    localparam int LINE_W = 16;
    localparam int SETTLE = 64;
    localparam int TMO    = 500;

    typedef enum int {EV_EN = 0, EV_LINE = 1, EV_DONE = 2, EV_ABORT = 3, EV_ERR = 4} ev_kind_t;

    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       idx;
        int       flag;  // cal_mode for EN/LINE, (ccd_en|busy) for terminal events
    } ev_t;

    logic clk_80M = 1'b0;
    logic rst_n   = 1'b0;
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_fail  = 0;
    ev_t  exp_q[$];
    bit   prev_en  = 1'b0;
    bit   prev_err = 1'b0;

    always #5 clk_80M = ~clk_80M;
    always @(posedge clk_80M) cyc <= cyc + 1;

    scan_line_sequencer_if #(.LINE_W(LINE_W)) bus ();

    scan_line_sequencer #(
        .SYNC_STAGES  (2),
        .SETTLE_CYCLES(SETTLE),
        .LINE_TIMEOUT (TMO),
        .LINE_W       (LINE_W)
    ) dut (
        .clk_80M(clk_80M),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    function automatic void push(ev_kind_t k, int c, int idx, int flag);
        ev_t e;
        e.kind = k; e.cyc = c; e.idx = idx; e.flag = flag;
        exp_q.push_back(e);
    endfunction

    function automatic void chk(string name, int got, int expv);
        n_cmp++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endfunction

    function automatic void check_ev(ev_kind_t k, int idx, int flag);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d idx=%0d flag=%0d, expected none",
                     k, cyc, idx, flag);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.idx != idx || e.flag != flag) begin
                n_fail++;
                $display("FAIL event: got kind=%0d cyc=%0d idx=%0d flag=%0d, expected kind=%0d cyc=%0d idx=%0d flag=%0d",
                         k, cyc, idx, flag, e.kind, e.cyc, e.idx, e.flag);
            end else begin
                $display("event kind=%0d cyc=%0d idx=%0d flag=%0d ok", k, cyc, idx, flag);
            end
        end
    endfunction

    // Monitor: fixed in-cycle order EN, LINE, DONE, ABORT, ERR.
    always @(negedge clk_80M) begin
        int term_flag;
        term_flag = ((bus.ccd_en === 1'b1) || (bus.busy === 1'b1)) ? 1 : 0;
        if (bus.ccd_en === 1'b1 && !prev_en)
            check_ev(EV_EN, int'(bus.line_idx), int'(bus.ccd_cal_mode));
        if (bus.line_done === 1'b1)
            check_ev(EV_LINE, int'(bus.line_idx), int'(bus.ccd_cal_mode));
        if (bus.done === 1'b1)
            check_ev(EV_DONE, int'(bus.line_idx), term_flag);
        if (bus.aborted === 1'b1)
            check_ev(EV_ABORT, int'(bus.line_idx), term_flag);
        if (bus.err === 1'b1 && !prev_err)
            check_ev(EV_ERR, int'(bus.line_idx), term_flag);
        prev_en  = (bus.ccd_en === 1'b1);
        prev_err = (bus.err === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_80M);
        #1;
    endtask

    // One engine line: random line length, then a falling flag. The counted
    // line end shows up 3 cycles after the fall.
    task automatic do_line(input int k, input int n, input bit cal_ph,
                           input bit fin, output int l);
        tick($urandom_range(20, 300));
        l = cyc + 3;
        // cal_mode is still 1 at the line end only when the pass heads into settle
        push(EV_LINE, l, (k + 1) % n, (cal_ph && !fin) ? 1 : 0);
        if (fin) push(EV_DONE, l, 0, 0);
        bus.pix_out_valid = 1'b0;
        tick(4);
        bus.pix_out_valid = 1'b1;
    endtask

    task automatic pulse_noise();
        bus.pix_out_valid = 1'b0;
        tick(4);
        bus.pix_out_valid = 1'b1;
    endtask

    task automatic run_pass(input int cal, input int num, input bit noise, input int abort_after);
        int s;
        int l;
        l = 0;
        bus.cal_lines = 8'(cal);
        bus.num_lines = LINE_W'(num);
        s = cyc + 1;
        if (cal == 0 && num == 0) push(EV_DONE, s, 0, 0);
        else push(EV_EN, s, 0, (cal > 0) ? 1 : 0);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        // later input changes must not affect the latched counts
        bus.cal_lines = 8'($urandom);
        bus.num_lines = LINE_W'($urandom);
        chk("err_after_start", int'(bus.err), 0);
        chk("busy_after_start", int'(bus.busy), (cal > 0 || num > 0) ? 1 : 0);

        for (int k = 0; k < cal; k++) begin
            if (noise && k == 0) begin
                tick(3);
                bus.start = 1'b1;
                tick(1);
                bus.start = 1'b0;
            end
            do_line(k, cal, 1'b1, (k == cal - 1) && (num == 0), l);
        end

        if (cal > 0 && num > 0) begin
            chk("settle_cal_mode_2nd", int'(bus.ccd_cal_mode), 0);
            chk("settle_en_low", int'(bus.ccd_en), 0);
            push(EV_EN, l + SETTLE, 0, 0);
            if (noise) begin
                tick(10);
                pulse_noise();
                tick(50);
            end else begin
                tick(SETTLE);
            end
        end

        for (int k = 0; k < num; k++) begin
            do_line(k, num, 1'b0, (k == num - 1) && (abort_after < 0), l);
            if (k == abort_after) begin
                tick($urandom_range(2, 40));
                push(EV_ABORT, cyc + 1, 0, 0);
                bus.abort = 1'b1;
                tick(1);
                bus.abort = 1'b0;
                tick(20);
                pulse_noise();
                break;
            end
        end

        tick(10);
        pulse_noise();  // idle edge must be ignored
        tick(10);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d events pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        int l;
        int cal;
        int num;
        int ab;
        int s;
        bus.start         = 1'b0;
        bus.abort         = 1'b0;
        bus.cal_lines     = '0;
        bus.num_lines     = '0;
        bus.pix_out_valid = 1'b1;
        rst_n             = 1'b0;
        tick(4);
        chk("rst_ccd_en", int'(bus.ccd_en), 0);
        chk("rst_cal_mode", int'(bus.ccd_cal_mode), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_line_idx", int'(bus.line_idx), 0);
        rst_n = 1'b1;
        tick(5);

        run_pass(2, 3, 1'b0, -1);   // nominal
        run_pass(0, 4, 1'b0, -1);   // calibration skipped
        run_pass(0, 0, 1'b0, -1);   // empty pass
        run_pass(1, 3, 1'b0, 0);    // abort after first image line

        // timeout with the flag held high
        bus.cal_lines = 8'd2;
        bus.num_lines = LINE_W'(1);
        s = cyc + 1;
        push(EV_EN, s, 0, 1);
        push(EV_ERR, s + TMO, 0, 0);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(TMO + 10);
        chk("err_sticky", int'(bus.err), 1);
        chk("err_ccd_en", int'(bus.ccd_en), 0);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        chk("err_ignores_abort", int'(bus.err), 1);
        run_pass(1, 1, 1'b0, -1);   // restart from ERR

        // reset in the middle of calibration
        bus.cal_lines = 8'd3;
        bus.num_lines = LINE_W'(2);
        push(EV_EN, cyc + 1, 0, 1);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        do_line(0, 3, 1'b1, 1'b0, l);
        tick(5);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("midrst_ccd_en", int'(bus.ccd_en), 0);
        chk("midrst_cal_mode", int'(bus.ccd_cal_mode), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_cal_active", int'(bus.cal_active), 0);
        chk("midrst_line_idx", int'(bus.line_idx), 0);
        chk("midrst_pulses", int'({bus.line_done, bus.done, bus.aborted, bus.err}), 0);
        tick(5);
        run_pass(2, 2, 1'b0, -1);

        run_pass(2, 2, 1'b1, -1);   // spurious edges and start while busy

        for (int i = 0; i < 6; i++) begin
            cal = $urandom_range(0, 3);
            num = $urandom_range(0, 3);
            ab  = (num >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(0, num - 2) : -1;
            run_pass(cal, num, 1'($urandom_range(0, 1)), ab);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
